// File: rtl/frame_reg_master.sv
// frame_reg_master: queues register writes and drains them to the sprite peripheral over Avalon-MM once per vsync.
// Optional FRAME_REG_FRAME_STATS_EN enables frame_count and the sticky missed_frame flag.
module frame_reg_master #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    input  logic        vga_vs,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [2:0]  avm_address,
    output logic [15:0] avm_writedata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        missed_frame
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
    logic          vs_q;
    logic [18:0]   mem_q [DEPTH];
    logic [18:0]   head;
    logic          full, empty, push, pop, vs_edge;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == DRAIN) && !avm_waitrequest;
    assign vs_edge   = !vga_vs && vs_q;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    assign avm_write      = state_q == DRAIN;
    assign avm_chipselect = avm_write;
    assign avm_address    = avm_write ? head[18:16] : 3'd0;
    assign avm_writedata  = avm_write ? head[15:0] : 16'd0;
    assign busy           = state_q != IDLE;
    assign frame_done     = state_q == DONE;

    // FIFO storage: data only, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_addr, cmd_data};
    end

    // Next state, pointer and drain-counter logic; the counter snapshot excludes later pushes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        case (state_q)
            IDLE: begin
                if (vs_edge) begin
                    state_d = empty ? DONE : DRAIN;
                    cnt_d   = wr_ptr_q - rd_ptr_q;
                end
            end
            DRAIN: begin
                if (pop) begin
                    cnt_d   = cnt_q - PW'(1);
                    state_d = (cnt_q == PW'(1)) ? DONE : DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; async reset aborts any write in flight and empties the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vs_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vs_q     <= vga_vs;
        end
    end

`ifdef FRAME_REG_FRAME_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic        missed_q, missed_d;

    // Frame counter wraps naturally; missed flag latches any vsync seen while not idle
    always_comb begin
        frame_count_d = frame_count_q + 16'(state_q == DONE);
        missed_d      = missed_q || (vs_edge && state_q != IDLE);
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count_q <= '0;
            missed_q      <= 1'b0;
        end else begin
            frame_count_q <= frame_count_d;
            missed_q      <= missed_d;
        end
    end

    assign frame_count  = frame_count_q;
    assign missed_frame = missed_q;
`else
    assign frame_count  = 16'd0;
    assign missed_frame = 1'b0;
`endif

endmodule

// File: tb/tb_frame_reg_master.sv
// tb_frame_reg_master: table-driven frames plus hand sequences, writes checked against a push-order scoreboard.
module tb_frame_reg_master;
`ifdef FRAME_REG_FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_addr = 3'd0;
    logic [15:0] cmd_data = 16'd0;
    logic        cmd_ready;
    logic        vga_vs = 1'b1;
    logic        avm_chipselect, avm_write;
    logic [2:0]  avm_address;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        busy, frame_done, missed_frame;
    logic [15:0] frame_count;

    frame_reg_master #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .vga_vs(vga_vs),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_address(avm_address),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .missed_frame(missed_frame)
    );

    always #10 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int exp_fc = 0;
    logic [18:0] sb[$];
    logic [18:0] sb_head;
    logic [18:0] prev_ad;
    logic        prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor away from the rising edge: scoreboard pushes, write completions, hold stability
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_write", avm_write, 1);
                check("hold_addr_data", {avm_address, avm_writedata}, prev_ad);
            end
            check("cs_eq_write", avm_chipselect, avm_write);
            if (avm_write && !avm_waitrequest) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got %0h expected none", {avm_address, avm_writedata});
                end else begin
                    sb_head = sb.pop_front();
                    check("write_addr_data", {avm_address, avm_writedata}, sb_head);
                end
            end
            prev_stall = avm_write && avm_waitrequest;
            prev_ad = {avm_address, avm_writedata};
            if (cmd_valid && cmd_ready) sb.push_back({cmd_addr, cmd_data});
            if (frame_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] a, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_data = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic vsync_edge();
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
    endtask

    task automatic run_drain(input int stall, output int cycles);
        int sc = 0;
        cycles = 0;
        while (busy && cycles < 200) begin
            if (avm_write) begin
                avm_waitrequest = (sc < stall);
                sc = (sc < stall) ? sc + 1 : 0;
            end else avm_waitrequest = 1'b0;
            tick();
            cycles++;
        end
        avm_waitrequest = 1'b0;
        if (busy) begin
            total++;
            $display("FAIL drain_timeout: got busy=1 expected idle within 200 cycles");
        end
    endtask

    task automatic frame(input string name, input int exp_writes, input int stall, input int exp_busy);
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int cyc;
        vsync_edge();
        run_drain(stall, cyc);
        exp_fc++;
        check({name, "_busy_cycles"}, cyc, exp_busy);
        check({name, "_writes"}, wr_cnt - w0, exp_writes);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_frame_count"}, frame_count, STATS ? exp_fc : 0);
        check({name, "_cmd_ready"}, cmd_ready, 1);
    endtask

    typedef struct {
        int n;
        int stall;
        int exp_writes;
        int exp_busy;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        int w0, d0;
        vecs[0] = '{2, 0, 2, 3};
        vecs[1] = '{1, 3, 1, 5};
        vecs[2] = '{0, 0, 0, 1};
        vecs[3] = '{3, 1, 3, 7};
        vecs[4] = '{4, 2, 4, 13};

        repeat (3) tick();
        check("rst_write", avm_write, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_addr_data", {avm_address, avm_writedata}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_missed", missed_frame, 0);
        reset = 1'b1;
        tick();
        check("rst_cmd_ready", cmd_ready, 1);

        push_cmd(3'd0, 16'h0064);
        push_cmd(3'd1, 16'h0003);
        frame("basic", 2, 0, 3);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) push_cmd(3'(i + v), 16'(16'h1111 * (v + 1) + i));
            frame($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].stall, vecs[v].exp_busy);
            check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
        end

        for (int i = 0; i < 8; i++) push_cmd(3'(7 - i), 16'(16'hA000 + i));
        check("full_cmd_ready", cmd_ready, 0);
        push_cmd(3'd5, 16'hDEAD);
        check("full_still_full", cmd_ready, 0);
        frame("full", 8, 0, 9);
        check("full_sb_empty", sb.size(), 0);

        w0 = wr_cnt;
        d0 = done_cnt;
        push_cmd(3'd0, 16'h0AAA);
        push_cmd(3'd1, 16'h0BBB);
        vsync_edge();
        cmd_valid = 1'b1;
        cmd_addr = 3'd2;
        cmd_data = 16'h0CCC;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("late_done_pulse", frame_done, 1);
        check("late_write_off", avm_write, 0);
        tick();
        check("late_idle", busy, 0);
        exp_fc++;
        check("late_writes", wr_cnt - w0, 2);
        check("late_done_cnt", done_cnt - d0, 1);
        check("late_pending", sb.size(), 1);
        check("late_frame_count", frame_count, STATS ? exp_fc : 0);
        frame("late_next", 1, 0, 2);

        push_cmd(3'd3, 16'hBEEF);
        vsync_edge();
        avm_waitrequest = 1'b1;
        tick();
        tick();
        vsync_edge();
        tick();
        check("missed_set", missed_frame, STATS ? 1 : 0);
        check("missed_still_draining", avm_write, 1);
        #3;
        reset = 1'b0;
        #1;
        check("abort_write", avm_write, 0);
        check("abort_cs", avm_chipselect, 0);
        check("abort_addr_data", {avm_address, avm_writedata}, 0);
        check("abort_busy", busy, 0);
        check("abort_frame_count", frame_count, 0);
        check("abort_missed", missed_frame, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        exp_fc = 0;
        check("abort_cmd_ready", cmd_ready, 1);
        frame("after_abort", 0, 0, 1);
        check("after_abort_missed", missed_frame, 0);

        vsync_edge();
        vsync_edge();
        tick();
        check("missed_in_done", missed_frame, STATS ? 1 : 0);
        exp_fc++;
        check("missed_in_done_fc", frame_count, STATS ? exp_fc : 0);
        push_cmd(3'd6, 16'h1234);
        frame("sticky", 1, 0, 2);
        check("missed_sticky", missed_frame, STATS ? 1 : 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/frame_reg_master.md
FRAME_REG_MASTER -- requirements
Module: frame_reg_master

Interface
REQ-001 SHALL have parameter: DEPTH, 8, command FIFO entries (power of two, 2..64).
REQ-002 SHALL have port: clk  in  1  system clock (50 MHz), all logic rising-edge.
REQ-003 SHALL have port: reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: cmd_valid in 1, cmd_addr in 3, cmd_data in 16: register write request from game logic.
REQ-005 SHALL have port: cmd_ready  out  1  FIFO can accept one command this cycle.
REQ-006 SHALL have port: vga_vs  in  1  active-low vertical sync from the VGA peripheral.
REQ-007 SHALL have ports: avm_chipselect out 1, avm_write out 1, avm_address out 3, avm_writedata out 16: Avalon-MM master write to the sprite peripheral register map.
REQ-008 SHALL have port: avm_waitrequest  in  1  slave stall.
REQ-009 SHALL have ports: busy out 1 (FSM not IDLE), frame_done out 1 (one-cycle pulse per completed drain).
REQ-010 SHALL have ports: frame_count out 16, missed_frame out 1 (sticky).

Function
REQ-011 SHALL push {cmd_addr, cmd_data} into the FIFO in every cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL equal !full, no same-cycle pass-through.
REQ-012 SHALL detect a vsync edge as vga_vs=0 in the current cycle and 1 in the previous registered sample.
REQ-013 SHALL implement FSM IDLE -> DRAIN -> DONE -> IDLE.
REQ-014 IDLE: on vsync edge with FIFO non-empty SHALL snapshot occupancy into a drain counter and enter DRAIN; with FIFO empty SHALL go directly to DONE.
REQ-015 DRAIN: SHALL drive avm_chipselect=1, avm_write=1 with FIFO head on avm_address/avm_writedata, held stable while avm_waitrequest=1.
REQ-016 A transfer completes in a cycle with avm_write=1 and avm_waitrequest=0; SHALL pop the head and decrement the drain counter in that cycle; next write SHALL begin the following cycle (back-to-back, one write per cycle max).
REQ-017 SHALL leave DRAIN after the transfer that brings the drain counter to 0, deasserting avm_write/avm_chipselect the next cycle.
REQ-018 Commands pushed after the snapshot SHALL NOT be written in the current frame; they remain for the next vsync edge.
REQ-019 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-020 DONE: SHALL assert frame_done for exactly one cycle, increment frame_count (wraps 0xFFFF -> 0), return to IDLE.
REQ-021 A vsync edge while in DRAIN or DONE SHALL be ignored and SHALL set missed_frame=1 until reset.
REQ-022 FIFO pointers SHALL be log2(DEPTH)+1 bits; full/empty derived from pointer MSB comparison.

Reset
REQ-023 On reset=0 SHALL immediately: FSM IDLE, FIFO empty, avm_chipselect=0, avm_write=0, avm_address=0, avm_writedata=0, cmd_ready=1 after release, busy=0, frame_done=0, frame_count=0, missed_frame=0, vsync sample register=1.
REQ-024 Reset asserted mid-DRAIN SHALL abort the pending write and discard all queued commands.

Configuration
REQ-025 Macro FRAME_REG_FRAME_STATS_EN: defined -> frame_count and missed_frame behave per REQ-020/021; undefined -> both outputs tied 0, counter and sticky logic removed, all other behaviour identical.

Verification
REQ-026 Push (0,0x0064),(1,0x0003); vga_vs 1->0; waitrequest=0 -> two back-to-back writes addr 0 data 0x0064 then addr 1 data 0x0003, frame_done pulse, frame_count=1.
REQ-027 One queued command, waitrequest high 3 cycles -> avm_write held 4 cycles with constant addr/data, exactly one pop.
REQ-028 Push 8 commands (DEPTH=8) -> cmd_ready=0; 9th cmd_valid not accepted; after drain cmd_ready=1, 8 writes observed in order.
REQ-029 Push 2, vsync edge, push 1 during DRAIN -> 2 writes this frame; third written only after next edge.
REQ-030 Second vsync edge during DRAIN with waitrequest stuck high -> missed_frame=1; release reset=0 mid-DRAIN -> avm_write=0 same cycle, FIFO empty, frame_count=0.
REQ-031 Vsync edge with empty FIFO -> no avm_write, frame_done pulse, frame_count increments.
